// File: rtl/peripheral_serial_addsub.sv
// Bit-serial adder/subtractor peripheral.
//
// Purpose: adds A+B+cin or subtracts A-B one bit per clock, LSB first. The
// result is assembled in an internal shift register. It is published to
// sum/cout/ovf only in the single FIN cycle, so those outputs never expose a
// partial value.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request a new operation (accepted only in IDLE or FIN)
//   sub    - 0: A+B+cin, 1: A-B (sampled with start)
//   a, b   - operands (sampled with start)
//   cin    - carry-in for add, ignored for subtract
//   busy   - high while bits are being processed (RUN)
//   done   - one-cycle pulse when the result is final (FIN)
//   sum    - registered result
//   cout   - final carry-out; for subtract 1 means no borrow
//   ovf    - signed overflow; tied to 0 unless PERIPHERAL_SERIAL_ADDSUB_OVF_EN
//            is defined
//
// Configuration macro: PERIPHERAL_SERIAL_ADDSUB_OVF_EN (overflow flag logic).
module peripheral_serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q, cout_q, busy_q, done_q;

    logic bit_s, carry_n, last_bit;

    always_comb begin
        bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
        carry_n  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        last_bit = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StFin: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        // Subtract as A + ~B + 1.
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= {bit_s, res_q[WIDTH-1:1]};
                    carry_q <= carry_n;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        sum_q   <= {bit_s, res_q[WIDTH-1:1]};
                        cout_q  <= carry_n;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StFin;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef PERIPHERAL_SERIAL_ADDSUB_OVF_EN
    logic ovf_q;

    // On the last bit carry_q is the carry into the MSB, carry_n the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= carry_q ^ carry_n;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
